ym2149_host: RTL and testbench
==============================

YM2149_HOST -- requirements
Module: ym2149_host

Interface
REQ-001 Parameter HOLD, default 2: number of CE ticks for each BDIR/BC active phase (legal range 1..15).
REQ-002 CLK  input  1  global clock; all state updates on its rising edge.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 CE  input  1  bus-timing enable; the sequencer advances only on CLK edges with CE=1.
REQ-005 REQ  input  1  host command strobe, sampled every CLK (not gated by CE).
REQ-006 WR  input  1  command type, 1 = register write, 0 = register read.
REQ-007 REG_ADDR  input  4  target PSG register number.
REQ-008 WDATA  input  8  write data (ignored for reads).
REQ-009 FULL  output  1  command FIFO holds 4 entries; REQ is refused.
REQ-010 BUSY  output  1  FIFO non-empty or sequencer not in IDLE.
REQ-011 DONE  output  1  one-CLK pulse when a command completes its final GAP phase.
REQ-012 RDATA  output  8  data captured by the last completed read; held until the next read completes.
REQ-013 BDIR  output  1  PSG bus direction, registered.
REQ-014 BC  output  1  PSG bus control, registered.
REQ-015 DA_OUT  output  8  data to PSG DI, registered.
REQ-016 DA_IN  input  8  data from PSG DO.

Function
REQ-017 Command FIFO: 4 entries of {WR, REG_ADDR, WDATA}; push when REQ=1 and FULL=0; REQ with FULL=1 is dropped.
REQ-018 A push in the same cycle as a pop is accepted only if FULL=0 before that cycle; no bypass of a full FIFO.
REQ-019 FIFO pointers wrap modulo 4; occupancy counter is 3 bits; FULL = (count==4).
REQ-020 States: IDLE, LATCH, GAP1, XFER, GAP2; phase counter 4 bits, loaded with HOLD-1 on entry to LATCH/XFER.
REQ-021 IDLE: on CE=1 with FIFO non-empty, pop head; go to LATCH if head address differs from cached address or cache is invalid, else go directly to XFER.
REQ-022 LATCH: BDIR=1, BC=1, DA_OUT=REG_ADDR zero-extended, for HOLD CE ticks; then GAP1; cache := REG_ADDR, valid := 1.
REQ-023 GAP1 and GAP2: BDIR=0, BC=0 for exactly 1 CE tick; guarantees a rising BDIR edge at each phase start.
REQ-024 XFER write: BDIR=1, BC=0, DA_OUT=WDATA for HOLD CE ticks.
REQ-025 XFER read: BDIR=0, BC=1, DA_OUT unchanged, for HOLD CE ticks; RDATA := DA_IN on the last XFER tick.
REQ-026 After XFER go to GAP2; on GAP2 exit assert DONE for one CLK and return to IDLE.
REQ-027 Timing in CE ticks from pop to DONE: uncached = 2*HOLD+2, cached = HOLD+1 (HOLD=2: 6 and 3).
REQ-028 CE=0 freezes state, phase counter and bus outputs; FIFO pushes continue.
REQ-029 Write to register 13 is issued even if same value as before (no data caching; envelope restart required).
REQ-030 Outputs change only on CLK edges; no combinational path from REQ to BDIR/BC/DA_OUT.

Reset
REQ-031 RESET_N=0 immediately forces: state IDLE, FIFO empty, address cache invalid, BDIR=0, BC=0, DA_OUT=0, RDATA=0, DONE=0, FULL=0, BUSY=0.
REQ-032 Reset mid-command aborts it with no DONE; the first command after reset always performs LATCH.

Verification
REQ-033 Reset, CE=1 always, HOLD=2; write reg 7=0x38 -> BDIR/BC 11 (DA_OUT=0x07) 2 ticks, 00 1 tick, 10 (DA_OUT=0x38) 2 ticks, 00 1 tick, DONE pulse; total 6 ticks.
REQ-034 Then write reg 7=0x3F -> no LATCH phase; DONE 3 ticks after pop; DA_OUT=0x3F during XFER.
REQ-035 Read reg 8 with DA_IN=0x0F -> LATCH with DA_OUT=0x08, XFER with BDIR=0,BC=1; RDATA=0x0F at DONE.
REQ-036 CE held 0, 5 REQ pulses -> first 4 accepted, FULL=1, 5th dropped; CE=1 -> exactly 4 DONE pulses in FIFO order.
REQ-037 Assert RESET_N=0 during XFER of a write -> BDIR=0, BC=0 in the same cycle, no DONE; next command starts with LATCH.
REQ-038 CE pulsed every 3rd CLK -> phase lengths scale to 3 CLKs per tick; bus values identical to REQ-033.

Source files
------------

// File: rtl/ym2149_host_if.sv
// Host-side command bus and PSG pin bus for the YM2149 host sequencer.
//   master : host/bench side, drives ce, command strobe fields and da_in
//   slave  : ym2149_host side, drives status, read data and PSG bus pins
interface ym2149_host_if;
  logic       ce;
  logic       req;
  logic       wr;
  logic [3:0] reg_addr;
  logic [7:0] wdata;
  logic       full;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       bdir;
  logic       bc;
  logic [7:0] da_out;
  logic [7:0] da_in;

  modport master (
    output ce, req, wr, reg_addr, wdata, da_in,
    input  full, busy, done, rdata, bdir, bc, da_out
  );

  modport slave (
    input  ce, req, wr, reg_addr, wdata, da_in,
    output full, busy, done, rdata, bdir, bc, da_out
  );
endinterface

// File: rtl/ym2149_host.sv
// YM2149 PSG host sequencer: queues register read/write commands in a
// 4-entry FIFO and plays them onto the BDIR/BC/DA bus with a latch-address
// phase (skipped when the address is already latched), a transfer phase and
// one-tick gaps so every active phase starts on a rising BDIR/BC edge.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : ym2149_host_if.slave (ce, req/wr/reg_addr/wdata in,
//             full/busy/done/rdata out, bdir/bc/da_out to PSG, da_in from PSG)
module ym2149_host #(
  parameter int unsigned HOLD = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  ym2149_host_if.slave  bus
);

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned PHW   = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP1,
    S_XFER,
    S_GAP2
  } state_t;

  state_t         state;
  logic [PHW-1:0] phase;
  cmd_t           cur;
  cmd_t           fifo_q [DEPTH];
  cmd_t           head;
  cmd_t           cmd_in;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic [AW-1:0]  cache_addr;
  logic           cache_valid;
  logic           push_c;
  logic           pop_c;
  logic           idle_nxt_c;

  logic           full_q;
  logic           busy_q;
  logic           done_q;
  logic [DW-1:0]  rdata_q;
  logic           bdir_q;
  logic           bc_q;
  logic [DW-1:0]  da_out_q;

  assign cmd_in     = '{wr: bus.wr, addr: bus.reg_addr, data: bus.wdata};
  assign head       = fifo_q[rd_ptr];
  // Push uses the registered full flag, so a full FIFO is never bypassed by a same-cycle pop.
  assign push_c     = bus.req && !full_q;
  assign pop_c      = (state == S_IDLE) && bus.ce && (count != '0);
  assign count_nxt  = count + CW'(push_c) - CW'(pop_c);
  // Sequencer will be in IDLE after this edge.
  assign idle_nxt_c = ((state == S_IDLE) && !pop_c) || ((state == S_GAP2) && bus.ce);

  assign bus.full   = full_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.bdir   = bdir_q;
  assign bus.bc     = bc_q;
  assign bus.da_out = da_out_q;

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr] <= cmd_in;
  end

  // FIFO pointers, status flags and the bus sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phase       <= '0;
      cur         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
      full_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      bdir_q      <= 1'b0;
      bc_q        <= 1'b0;
      da_out_q    <= '0;
    end else begin
      done_q <= 1'b0;
      count  <= count_nxt;
      full_q <= (count_nxt == CW'(DEPTH));
      busy_q <= (count_nxt != '0) || !idle_nxt_c;
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);

      if (bus.ce) begin
        case (state)
          S_IDLE: begin
            if (count != '0) begin
              cur   <= head;
              phase <= PHW'(HOLD - 1);
              if (!cache_valid || (cache_addr != head.addr)) begin
                state    <= S_LATCH;
                bdir_q   <= 1'b1;
                bc_q     <= 1'b1;
                da_out_q <= DW'(head.addr);
              end else begin
                state  <= S_XFER;
                bdir_q <= head.wr;
                bc_q   <= !head.wr;
                if (head.wr) da_out_q <= head.data;
              end
            end
          end
          S_LATCH: begin
            if (phase == '0) begin
              state       <= S_GAP1;
              bdir_q      <= 1'b0;
              bc_q        <= 1'b0;
              cache_addr  <= cur.addr;
              cache_valid <= 1'b1;
            end else begin
              phase <= phase - PHW'(1);
            end
          end
          S_GAP1: begin
            state  <= S_XFER;
            phase  <= PHW'(HOLD - 1);
            bdir_q <= cur.wr;
            bc_q   <= !cur.wr;
            if (cur.wr) da_out_q <= cur.data;
          end
          S_XFER: begin
            if (phase == '0) begin
              state  <= S_GAP2;
              bdir_q <= 1'b0;
              bc_q   <= 1'b0;
              if (!cur.wr) rdata_q <= bus.da_in;
            end else begin
              phase <= phase - PHW'(1);
            end
          end
          S_GAP2: begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
          default: begin
            state  <= S_IDLE;
            bdir_q <= 1'b0;
            bc_q   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ym2149_host.sv
// Scoreboard bench for ym2149_host: each accepted command pushes its expected
// bus behaviour; a negedge monitor measures each command's phases and compares
// them against the scoreboard head when DONE pulses.
module tb_ym2149_host;

  localparam int unsigned HOLD = 2;

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic       cached;
    logic [7:0] rdata;
  } exp_t;

  logic clk;
  logic reset_n;
  ym2149_host_if bus ();

  ym2149_host #(.HOLD(HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   checks;
  int   errors;
  int   done_cnt;
  int   mode;
  int   cpt;
  exp_t sb [$];

  // reference model of the address cache and read-data register
  logic       m_valid;
  logic [3:0] m_addr;
  logic [7:0] m_rdata;

  // monitor state
  logic       active;
  int         span;
  int         lat;
  int         xf;
  logic [7:0] lat_addr;
  logic [7:0] xdata;
  logic       xdir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CE pattern: 0 = always on, 1 = held off, 2 = every third clock
  initial begin
    int k;
    k = 0;
    bus.ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (mode)
        0:       bus.ce = 1'b1;
        1:       bus.ce = 1'b0;
        default: bus.ce = ((k % 3) == 0);
      endcase
    end
  end

  // Measure each command's phases and compare at DONE.
  always @(negedge clk) begin
    if (!reset_n) begin
      active = 1'b0;
    end else begin
      if (!active && (bus.bdir || bus.bc)) begin
        active = 1'b1;
        span = 0;
        lat = 0;
        xf = 0;
        lat_addr = '0;
        xdata = '0;
        xdir = 1'b0;
      end
      if (active) begin
        span++;
        if (bus.bdir && bus.bc) begin
          lat++;
          lat_addr = bus.da_out;
        end else if (bus.bdir) begin
          xf++;
          xdir = 1'b1;
          xdata = bus.da_out;
        end else if (bus.bc) begin
          xf++;
          xdir = 1'b0;
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          int   ticks;
          e = sb.pop_front();
          ticks = e.cached ? (HOLD + 1) : (2 * HOLD + 2);
          check("span_clks", span, cpt * ticks + 1);
          check("latch_clks", lat, e.cached ? 0 : cpt * HOLD);
          if (!e.cached) check("latch_addr", lat_addr, {4'h0, e.addr});
          check("xfer_clks", xf, cpt * HOLD);
          check("xfer_dir", xdir, e.wr);
          if (e.wr) check("xfer_data", xdata, e.data);
          check("rdata", bus.rdata, e.rdata);
        end
        active = 1'b0;
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input logic acc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.wr = w;
    bus.reg_addr = a;
    bus.wdata = d;
    if (acc) begin
      e.wr = w;
      e.addr = a;
      e.data = d;
      e.cached = m_valid && (m_addr == a);
      m_valid = 1'b1;
      m_addr = a;
      if (!w) m_rdata = bus.da_in;
      e.rdata = m_rdata;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (((sb.size() != 0) || bus.busy) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int d0;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    mode = 0;
    cpt = 1;
    m_valid = 1'b0;
    m_addr = '0;
    m_rdata = '0;
    active = 1'b0;
    reset_n = 1'b0;
    bus.req = 1'b0;
    bus.wr = 1'b0;
    bus.reg_addr = '0;
    bus.wdata = '0;
    bus.da_in = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_bdir", bus.bdir, 0);
    check("rst_bc", bus.bc, 0);
    check("rst_da_out", bus.da_out, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_done", bus.done, 0);
    check("rst_full", bus.full, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;

    // uncached write, cached write, read, repeated envelope-shape writes
    issue(1'b1, 4'd7, 8'h38, 1'b1);
    wait_idle(100);
    issue(1'b1, 4'd7, 8'h3F, 1'b1);
    wait_idle(100);
    bus.da_in = 8'h0F;
    issue(1'b0, 4'd8, 8'h00, 1'b1);
    wait_idle(100);
    issue(1'b1, 4'd13, 8'h0A, 1'b1);
    issue(1'b1, 4'd13, 8'h0A, 1'b1);
    wait_idle(100);

    // fill the FIFO with CE frozen, fifth request dropped
    mode = 1;
    repeat (2) @(posedge clk);
    bus.da_in = 8'h5A;
    d0 = done_cnt;
    issue(1'b1, 4'd1, 8'h11, 1'b1);
    issue(1'b1, 4'd1, 8'h22, 1'b1);
    issue(1'b0, 4'd2, 8'h00, 1'b1);
    issue(1'b1, 4'd3, 8'h33, 1'b1);
    check("full_after4", bus.full, 1);
    check("busy_frozen", bus.busy, 1);
    check("bdir_frozen", bus.bdir, 0);
    issue(1'b1, 4'd4, 8'h44, 1'b0);
    check("full_after5", bus.full, 1);
    mode = 0;
    wait_idle(200);
    check("done_count4", done_cnt - d0, 4);
    check("full_drained", bus.full, 0);

    // reset during the transfer phase of a write
    issue(1'b1, 4'd7, 8'h55, 1'b1);
    n = 0;
    while (!(bus.bdir && !bus.bc) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("xfer_wait_timeout", 0, 1);
    d0 = done_cnt;
    #1;
    reset_n = 1'b0;
    sb.delete();
    m_valid = 1'b0;
    m_rdata = '0;
    #1;
    check("abort_bdir", bus.bdir, 0);
    check("abort_bc", bus.bc, 0);
    check("abort_busy", bus.busy, 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rdata", bus.rdata, 0);
    reset_n = 1'b1;
    issue(1'b1, 4'd7, 8'h38, 1'b1);
    wait_idle(100);

    // CE every third clock scales each phase to three clocks
    mode = 2;
    cpt = 3;
    bus.da_in = 8'hA5;
    issue(1'b1, 4'd5, 8'h38, 1'b1);
    wait_idle(300);
    issue(1'b0, 4'd5, 8'h00, 1'b1);
    wait_idle(300);
    check("final_rdata", bus.rdata, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
